// File: rtl/hazard_control_unit_pkg.sv
// Shared types for the hazard control unit: the control bundle driven into the
// pipeline register bank, the FSM state encodings and the register-index width.
package hazard_control_unit_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int EXCPT_W    = 3;

    // Stall/flush bundle consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
    typedef struct packed {
        logic stall;
        logic stall_mul;
        logic takebranch;
        logic dcache_stall;
        logic load_use_stall;
    } control_signals_t;

    localparam control_signals_t CTRL_NONE = '0;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

    typedef enum logic {
        DC_IDLE = 1'b0,
        DC_WAIT = 1'b1
    } dc_state_e;

    // True when an ID source operand is actually read and names the given EX destination.
    function automatic logic src_matches(input logic                  use_src,
                                         input logic [REG_ADDR_W-1:0] src,
                                         input logic [REG_ADDR_W-1:0] dst);
        return use_src && (src == dst);
    endfunction

endpackage

// File: rtl/hcu_load_use_detect.sv
// Load-use comparator: flags an ID instruction that needs the result of a load
// still sitting in EX. x0 is never a real dependency.
module hcu_load_use_detect
    import hazard_control_unit_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    output logic                  hazard
);

    logic rd_nonzero;

    assign rd_nonzero = (ex_rd != '0);

    // Raw hazard, before suppression by the longer stall sources.
    always_comb begin
        hazard = ex_is_load && rd_nonzero &&
                 (src_matches(id_use_rs1, id_rs1, ex_rd) ||
                  src_matches(id_use_rs2, id_rs2, ex_rd));
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard control unit: merges load-use, multi-cycle MUL, D-cache miss and branch
// flush sources into one control bundle for the pipeline register bank, and
// counts stalled cycles in a saturating perf counter.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int PERF_W      = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  ex_mul_start,
    input  logic                  ex_branch_taken,
    input  logic                  dcache_miss,
    input  logic                  dcache_fill_done,
    input  logic [EXCPT_W-1:0]    excpt_in,
    output control_signals_t      ctrl_signals,
    output logic                  pc_write_en,
    output logic [PERF_W-1:0]     stall_cycles
);

    // The counter holds MUL_LATENCY-2 at most; stall_mul spans MUL_LATENCY-1 cycles.
    localparam int                CNT_W        = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0]  MUL_CNT_INIT = CNT_W'(MUL_LATENCY - 2);

    mul_state_e       mul_state, mul_state_next;
    logic [CNT_W-1:0] mul_cnt, mul_cnt_next;
    dc_state_e        dc_state, dc_state_next;
    logic             pending_branch, pending_branch_next;

    logic load_use_raw;
    logic excpt_active;
    logic stall_mul_int;
    logic dcache_stall_int;
    logic load_use_int;
    logic stall_int;
    logic takebranch_int;

    hcu_load_use_detect u_load_use (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .hazard     (load_use_raw)
    );

    assign excpt_active  = (excpt_in != '0);
    assign stall_mul_int = (mul_state == MUL_BUSY);

    // MUL occupancy FSM: next state and countdown; an exception aborts the multiply.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mul_state_next = mul_state;
        mul_cnt_next   = mul_cnt;
        if (excpt_active) begin
            mul_state_next = MUL_IDLE;
            mul_cnt_next   = '0;
        end else begin
            unique case (mul_state)
                MUL_IDLE: begin
                    if (ex_mul_start) begin
                        mul_state_next = MUL_BUSY;
                        mul_cnt_next   = MUL_CNT_INIT;
                    end
                end
                MUL_BUSY: begin
                    if (mul_cnt == '0) begin
                        mul_state_next = MUL_IDLE;
                    end else begin
                        mul_cnt_next = mul_cnt - CNT_W'(1);
                    end
                end
                default: mul_state_next = MUL_IDLE;
            endcase
        end
    end

    // D-cache wait FSM: stalls combinationally on a miss and releases on fill_done.
    // Exceptions do not touch it, so an outstanding refill always drains.
    always_comb begin
        dc_state_next    = dc_state;
        dcache_stall_int = 1'b0;
        unique case (dc_state)
            DC_IDLE: begin
                // A miss that fills in the same cycle behaves as a hit.
                if (dcache_miss && !dcache_fill_done) begin
                    dc_state_next    = DC_WAIT;
                    dcache_stall_int = 1'b1;
                end
            end
            DC_WAIT: begin
                if (dcache_fill_done) begin
                    dc_state_next = DC_IDLE;
                end else begin
                    dcache_stall_int = 1'b1;
                end
            end
            default: dc_state_next = DC_IDLE;
        endcase
    end

    // Stall merge and branch release; load-use is hidden behind the longer stalls.
    always_comb begin
        load_use_int   = load_use_raw && !stall_mul_int && !dcache_stall_int;
        stall_int      = stall_mul_int || dcache_stall_int || load_use_int;
        takebranch_int = (ex_branch_taken || pending_branch) && !stall_int;
    end

    // Pending-branch latch: remembers a taken branch that arrived during a stall.
    always_comb begin
        pending_branch_next = pending_branch;
        if (excpt_active) begin
            pending_branch_next = 1'b0;
        end else if (takebranch_int) begin
            pending_branch_next = 1'b0;
        end else if (ex_branch_taken && stall_int) begin
            pending_branch_next = 1'b1;
        end
    end

    // Output bundle: quiet during reset, fully suppressed during an exception.
    always_comb begin
        ctrl_signals = CTRL_NONE;
        pc_write_en  = 1'b1;
        if (reset_n) begin
            if (excpt_active) begin
                pc_write_en = 1'b0;
            end else begin
                ctrl_signals.stall          = stall_int;
                ctrl_signals.stall_mul      = stall_mul_int;
                ctrl_signals.takebranch     = takebranch_int;
                ctrl_signals.dcache_stall   = dcache_stall_int;
                ctrl_signals.load_use_stall = load_use_int;
                pc_write_en                 = !stall_int;
            end
        end
    end

    // State registers for both FSMs and the pending-branch latch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mul_state      <= MUL_IDLE;
            mul_cnt        <= '0;
            dc_state       <= DC_IDLE;
            pending_branch <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            mul_state      <= mul_state_next;
            mul_cnt        <= mul_cnt_next;
            dc_state       <= dc_state_next;
            pending_branch <= pending_branch_next;
        end
    end

    // Saturating count of cycles in which the consumer sees stall asserted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (ctrl_signals.stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed scenarios followed by random
// traffic, each cycle's expectation produced by a cycle-level behavioural model.
module tb_hazard_control_unit;
    import hazard_control_unit_pkg::*;

    localparam int MUL_LATENCY = 4;
    localparam int PERF_W      = 6;
    localparam int SAT         = (1 << PERF_W) - 1;

    logic                  clock;
    logic                  reset_n;
    logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
    logic                  id_use_rs1, id_use_rs2;
    logic                  ex_is_load, ex_mul_start, ex_branch_taken;
    logic                  dcache_miss, dcache_fill_done;
    logic [EXCPT_W-1:0]    excpt_in;
    control_signals_t      ctrl_signals;
    logic                  pc_write_en;
    logic [PERF_W-1:0]     stall_cycles;

    hazard_control_unit #(.MUL_LATENCY(MUL_LATENCY), .PERF_W(PERF_W)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_use_rs1       (id_use_rs1),
        .id_use_rs2       (id_use_rs2),
        .ex_rd            (ex_rd),
        .ex_is_load       (ex_is_load),
        .ex_mul_start     (ex_mul_start),
        .ex_branch_taken  (ex_branch_taken),
        .dcache_miss      (dcache_miss),
        .dcache_fill_done (dcache_fill_done),
        .excpt_in         (excpt_in),
        .ctrl_signals     (ctrl_signals),
        .pc_write_en      (pc_write_en),
        .stall_cycles     (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic                  rst_n;
        logic [REG_ADDR_W-1:0] rs1, rs2, rd;
        logic                  u1, u2, ld, ms, br, miss, fill;
        logic [EXCPT_W-1:0]    exc;
    } stim_t;

    typedef struct {
        string             tag;
        control_signals_t  ctrl;
        logic              pc;
        logic [PERF_W-1:0] cnt;
    } exp_t;

    stim_t s;
    exp_t  sb[$];
    int    vectors     = 0;
    int    miscompares = 0;

    // Reference model state, kept in spec terms rather than FSM encodings.
    int mul_left = 0;  // stall_mul cycles still owed by the current multiply
    bit dc_wait  = 0;  // a refill is outstanding
    bit pend     = 0;  // a taken branch is waiting for a free cycle
    int perf     = 0;  // stalled cycles seen so far

    task automatic quiet();
        s.rst_n = 1'b1;
        s.rs1 = '0; s.rs2 = '0; s.rd = '0;
        s.u1 = 0; s.u2 = 0; s.ld = 0; s.ms = 0; s.br = 0; s.miss = 0; s.fill = 0;
        s.exc = '0;
    endtask

    // Drive one cycle of stimulus, derive its expected outputs, advance the model.
    task automatic apply(input string tag);
        exp_t e;
        bit s_mul, s_dc, lu, st, tb, exc;
        @(posedge clock);
        #1;
        reset_n          = s.rst_n;
        id_rs1           = s.rs1;
        id_rs2           = s.rs2;
        ex_rd            = s.rd;
        id_use_rs1       = s.u1;
        id_use_rs2       = s.u2;
        ex_is_load       = s.ld;
        ex_mul_start     = s.ms;
        ex_branch_taken  = s.br;
        dcache_miss      = s.miss;
        dcache_fill_done = s.fill;
        excpt_in         = s.exc;
        e.tag = tag;
        if (!s.rst_n) begin
            e.ctrl = '0; e.pc = 1'b1; e.cnt = '0;
            mul_left = 0; dc_wait = 0; pend = 0; perf = 0;
        end else begin
            s_mul = (mul_left > 0);
            s_dc  = dc_wait ? !s.fill : (s.miss && !s.fill);
            lu    = s.ld && (s.rd != 0) &&
                    ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd)) && !s_mul && !s_dc;
            st    = s_mul || s_dc || lu;
            tb    = (s.br || pend) && !st;
            exc   = (s.exc != 0);
            if (exc) begin
                e.ctrl = '0;
                e.pc   = 1'b0;
            end else begin
                e.ctrl.stall          = st;
                e.ctrl.stall_mul      = s_mul;
                e.ctrl.takebranch     = tb;
                e.ctrl.dcache_stall   = s_dc;
                e.ctrl.load_use_stall = lu;
                e.pc                  = !st;
            end
            e.cnt = PERF_W'(perf);
            if (e.ctrl.stall && perf < SAT) perf++;
            if (exc)               mul_left = 0;
            else if (mul_left > 0) mul_left--;
            else if (s.ms)         mul_left = MUL_LATENCY - 1;
            if (dc_wait && s.fill)                   dc_wait = 0;
            else if (!dc_wait && s.miss && !s.fill)  dc_wait = 1;
            if (exc)             pend = 0;
            else if (tb)         pend = 0;
            else if (s.br && st) pend = 1;
        end
        sb.push_back(e);
    endtask

    // Monitor: compare the DUT mid-cycle against the oldest outstanding expectation.
    always @(negedge clock) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if ({ctrl_signals, pc_write_en, stall_cycles} !== {e.ctrl, e.pc, e.cnt}) begin
                miscompares++;
                $display("FAIL %s t=%0t got ctrl=%b pc_we=%b cnt=%0d expected ctrl=%b pc_we=%b cnt=%0d",
                         e.tag, $time, ctrl_signals, pc_write_en, stall_cycles,
                         e.ctrl, e.pc, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t bench did not finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        quiet();
        reset_n = 1'b0;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0; ex_mul_start = 0;
        ex_branch_taken = 0; dcache_miss = 0; dcache_fill_done = 0; excpt_in = '0;

        s.rst_n = 1'b0; apply("reset"); apply("reset_hold");
        quiet(); apply("idle");

        // Load-use detection, including the x0 and unused-operand cases.
        s.ld = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1; apply("lu_rs1_hit");
        quiet(); apply("lu_gone");
        s.ld = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1; apply("lu_x0");
        quiet(); s.ld = 1; s.rd = 7; s.rs1 = 3; s.u1 = 1; s.rs2 = 7; apply("lu_rs2_unused");
        s.u2 = 1; apply("lu_rs2_hit");

        // MUL occupancy: three stall cycles starting the cycle after the pulse.
        quiet(); s.ms = 1; apply("mul_start");
        quiet(); repeat (4) apply("mul_busy");

        // D-cache miss with fill five cycles later, then miss+fill together.
        s.miss = 1; apply("dc_miss");
        quiet(); repeat (4) apply("dc_wait");
        s.fill = 1; apply("dc_fill");
        quiet(); s.miss = 1; s.fill = 1; apply("dc_hit_fill");
        quiet(); apply("idle");

        // Branch arriving during a MUL stall fires once on the first free cycle.
        s.ms = 1; apply("br_mul_start");
        quiet(); s.br = 1; apply("br_in_mul");
        quiet(); repeat (4) apply("br_pending");

        // Exception mid-MUL with a pending branch while a refill is outstanding.
        s.miss = 1; apply("ex_miss");
        quiet(); s.ms = 1; apply("ex_mul_start");
        quiet(); s.br = 1; apply("ex_br");
        quiet(); s.exc = 3'b010; apply("ex_excpt");
        quiet(); repeat (2) apply("ex_after");
        s.fill = 1; apply("ex_fill");
        quiet(); repeat (2) apply("ex_idle");

        // Asynchronous reset in the middle of a MUL and a miss, with busy inputs.
        s.ms = 1; apply("rst_mul_start");
        quiet(); s.miss = 1; apply("rst_miss");
        quiet(); apply("rst_wait");
        s.rst_n = 0; s.miss = 1; s.ld = 1; s.rd = 4; s.rs1 = 4; s.u1 = 1; s.br = 1; s.exc = 3'b001;
        apply("rst_async");
        quiet(); apply("rst_released");

        // Hold a refill long enough to saturate the perf counter.
        s.miss = 1; apply("sat_miss");
        quiet(); repeat (70) apply("sat_wait");
        s.fill = 1; apply("sat_fill");
        quiet(); repeat (2) apply("sat_hold");

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            s.rst_n = ($urandom_range(0, 63) != 0);
            s.rs1   = 5'($urandom_range(0, 3));
            s.rs2   = 5'($urandom_range(0, 3));
            s.rd    = 5'($urandom_range(0, 3));
            s.u1    = 1'($urandom_range(0, 1));
            s.u2    = 1'($urandom_range(0, 1));
            s.ld    = 1'($urandom_range(0, 1));
            s.ms    = ($urandom_range(0, 7) == 0);
            s.br    = ($urandom_range(0, 3) == 0);
            s.miss  = ($urandom_range(0, 5) == 0);
            s.fill  = ($urandom_range(0, 3) == 0);
            s.exc   = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            apply("random");
        end

        @(posedge clock);
        @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
